// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared FSM states, register offsets and ID read formatting
package intr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} state_t;
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_ID   = 2'd2;
  localparam logic [1:0] REG_ACK  = 2'd3;
  function automatic logic [7:0] id_byte(input logic act, input logic [2:0] id);
    return {act, 4'b0, id};
  endfunction
endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: lowest-index-wins priority encoder
module intr_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               found,
  output logic [2:0]         idx
);
  always_comb begin
    found = |req;
    idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (req[i]) idx = 3'(i);
  end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latching, masked, prioritised interrupt controller on the MCU I/O bus
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] BASE_ID   = 8'hE0,
  parameter int         INT_PULSE = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ_SRC,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         PORT_DIN,
  output logic [7:0]         RD_DATA,
  output logic               RD_HIT,
  output logic               INTERRUPT,
  output logic               ACTIVE
);
  state_t state, nxt;
  logic [NUM_SRC-1:0] mask, pend, prev_src, rise, clr, w1c;
  logic [7:0] off;
  logic [3:0] cnt;
  logic [2:0] active_id, sel;
  logic found, dispatch, ack_seen, wr, wr_mask, wr_pend, wr_ack;
  intr_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (.req(pend & mask), .found(found), .idx(sel));
  assign off       = PORT_ID - BASE_ID;
  assign RD_HIT    = off < 8'd4;
  assign wr        = IO_STRB && RD_HIT;
  assign wr_mask   = wr && off[1:0] == REG_MASK;
  assign wr_pend   = wr && off[1:0] == REG_PEND;
  assign wr_ack    = wr && off[1:0] == REG_ACK;
  assign rise      = IRQ_SRC & ~prev_src;
  assign w1c       = wr_pend ? PORT_DIN[NUM_SRC-1:0] : '0;
  assign dispatch  = state == IDLE && found;
  assign INTERRUPT = state == ASSERT;
  assign ACTIVE    = state != IDLE;
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) clr[i] = dispatch && sel == 3'(i);
  end
  always_comb begin
    nxt = state == IDLE   ? (found ? ASSERT : IDLE)
        : state == ASSERT ? (cnt == 4'd1 ? ((ack_seen || wr_ack) ? IDLE : WAIT_ACK) : ASSERT)
        : (wr_ack ? IDLE : WAIT_ACK);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= nxt;
  // a fresh edge outranks both the W1C write and the dispatch clear
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      mask      <= '0;
      pend      <= '0;
      prev_src  <= '0;
      active_id <= 3'd0;
      cnt       <= 4'd0;
      ack_seen  <= 1'b0;
    end else begin
      prev_src <= IRQ_SRC;
      pend     <= (pend & ~clr & ~w1c) | rise;
      if (wr_mask) mask <= PORT_DIN[NUM_SRC-1:0];
      if (dispatch) begin
        active_id <= sel;
        cnt       <= 4'(INT_PULSE);
      end else if (state == ASSERT) cnt <= cnt - 4'd1;
      ack_seen <= state == ASSERT && (ack_seen || wr_ack);
    end
  always_comb
    RD_DATA = !RD_HIT                ? 8'h00
            : off[1:0] == REG_MASK  ? 8'(mask)
            : off[1:0] == REG_PEND  ? 8'(pend)
            : off[1:0] == REG_ID    ? id_byte(ACTIVE, active_id)
            : 8'h00;
endmodule
